// File: rtl/mux_scan_seq_pkg.sv
// Shared types and defaults for the mux select scan sequencer.
package mux_scan_pkg;

   localparam int NUM_LEVELS_DEF = 5;
   localparam int WIDTH_DEF      = 2 ** (NUM_LEVELS_DEF - 1);
   localparam int SEL_W_DEF      = NUM_LEVELS_DEF - 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } scan_state_t;

   // Settle counter width; a zero-cycle settle still gets a 1-bit counter.
   function automatic int cnt_width(input int settle_cycles);
      return (settle_cycles < 1) ? 1 : $clog2(settle_cycles + 1);
   endfunction

endpackage

// File: rtl/mux_scan_seq_if.sv
// Control, mux feedback and result signals between the scan sequencer and its user.
interface mux_scan_seq_if
   import mux_scan_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SEL_W = SEL_W_DEF
);

   logic             start;
   logic             cont;
   logic             abort;
   logic             mux_out;
   logic [SEL_W-1:0] sel;
   logic             busy;
   logic [WIDTH-1:0] data_out;
   logic             valid;

   modport master (
      output start, cont, abort, mux_out,
      input  sel, busy, data_out, valid
   );

   modport slave (
      input  start, cont, abort, mux_out,
      output sel, busy, data_out, valid
   );

endinterface

// File: rtl/mux_scan_seq_settle_timer.sv
// Per-channel settle timer: counts up from a load, flags the last settle cycle.
module settle_timer
   import mux_scan_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic tc
);

   localparam int CW = cnt_width(SETTLE_CYCLES);
   localparam logic [CW-1:0] TC_VAL = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

   logic [CW-1:0] cnt;

   // Load clears the count; enable advances it while the channel settles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/mux_scan_seq.sv
// Select sequencer: walks sel across every mux channel, samples mux_out after
// a settle delay and delivers the assembled word with a one-cycle valid.
//
// state  | meaning
// IDLE   | waiting for start
// SETTLE | sel just changed, letting the mux output settle
// SAMPLE | capture mux_out into bit sel, then advance or finish
// DONE   | publish the captured word, restart if continuous
module mux_scan_seq
   import mux_scan_pkg::*;
#(
   parameter int NUM_LEVELS    = NUM_LEVELS_DEF,
   parameter int WIDTH         = 2 ** (NUM_LEVELS - 1),
   parameter int SEL_W         = NUM_LEVELS - 1,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   mux_scan_seq_if.slave  bus
);

   // With no settle time a channel goes straight to sampling.
   localparam scan_state_t FIRST = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);

   scan_state_t      state;
   logic [WIDTH-1:0] capture;
   logic             tmr_load;
   logic             tmr_en;
   logic             tmr_tc;

   assign tmr_en   = (state == SETTLE);
   assign tmr_load = (state != SETTLE);

   settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_settle_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (tmr_load),
      .en    (tmr_en),
      .tc    (tmr_tc)
   );

   // Scan FSM with sel counter, capture register and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         bus.sel      <= '0;
         bus.busy     <= 1'b0;
         bus.data_out <= '0;
         bus.valid    <= 1'b0;
         capture      <= '0;
      end else begin
         bus.valid <= 1'b0;
         if (bus.abort) begin
            // Abort wins everywhere; any partial word is thrown away.
            state    <= IDLE;
            bus.sel  <= '0;
            bus.busy <= 1'b0;
            capture  <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.start) begin
                     bus.sel  <= '0;
                     capture  <= '0;
                     bus.busy <= 1'b1;
                     state    <= FIRST;
                  end
               end
               SETTLE: begin
                  if (tmr_tc) begin
                     state <= SAMPLE;
                  end
               end
               SAMPLE: begin
                  capture[bus.sel] <= bus.mux_out;
                  if (bus.sel == SEL_LAST) begin
                     state <= DONE;
                  end else begin
                     bus.sel <= bus.sel + SEL_W'(1);
                     state   <= FIRST;
                  end
               end
               DONE: begin
                  bus.data_out <= capture;
                  bus.valid    <= 1'b1;
                  if (bus.cont) begin
                     bus.sel <= '0;
                     capture <= '0;
                     state   <= FIRST;
                  end else begin
                     bus.busy <= 1'b0;
                     state    <= IDLE;
                  end
               end
               default: begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mux_scan_seq.sv
// Scoreboard bench: two sequencers (settle 1 and settle 0) driven by a behavioural 16:1 mux.
module tb_mux_scan_seq;
   import mux_scan_pkg::*;

   localparam int W    = 16;
   localparam int SW   = 4;
   localparam int LAT0 = W * (1 + 1) + 1;
   localparam int LAT1 = W * (0 + 1) + 1;

   typedef struct {
      logic [W-1:0] word;
      int           t;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic [W-1:0] data0 = '0;
   logic [W-1:0] data1 = '0;
   int cyc = 0;
   int checks = 0;
   int failures = 0;
   exp_t q0[$];
   exp_t q1[$];
   logic [W-1:0] last0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   mux_scan_seq_if #(.WIDTH(W), .SEL_W(SW)) if0 ();
   mux_scan_seq_if #(.WIDTH(W), .SEL_W(SW)) if1 ();

   // Behavioural 16:1 mux: output is the data bit addressed by sel.
   assign if0.mux_out = data0[if0.sel];
   assign if1.mux_out = data1[if1.sel];

   mux_scan_seq #(.NUM_LEVELS(5), .SETTLE_CYCLES(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   mux_scan_seq #(.NUM_LEVELS(5), .SETTLE_CYCLES(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Monitor: every valid pulse is matched against the oldest expected word.
   always @(negedge clk) begin : mon
      exp_t e;
      if (if0.valid === 1'b1) begin
         if (q0.size() == 0) begin
            checks++; failures++;
            $display("FAIL dut0_unexpected_valid: got data_out %h, required no valid", if0.data_out);
         end else begin
            e = q0.pop_front();
            check("dut0_word", 32'(if0.data_out), 32'(e.word));
            check("dut0_valid_cycle", cyc, e.t);
         end
      end
      if (if1.valid === 1'b1) begin
         if (q1.size() == 0) begin
            checks++; failures++;
            $display("FAIL dut1_unexpected_valid: got data_out %h, required no valid", if1.data_out);
         end else begin
            e = q1.pop_front();
            check("dut1_word", 32'(if1.data_out), 32'(e.word));
            check("dut1_valid_cycle", cyc, e.t);
         end
      end
   end

   // Start pulse; the word the mux presents is the word the scan must return.
   task automatic pulse_start(input int which, input bit expect_word);
      @(negedge clk);
      if (which == 0) begin
         if0.start = 1'b1;
         if (expect_word) q0.push_back('{word: data0, t: cyc + 1 + LAT0});
      end else begin
         if1.start = 1'b1;
         if (expect_word) q1.push_back('{word: data1, t: cyc + 1 + LAT1});
      end
      @(negedge clk);
      if0.start = 1'b0;
      if1.start = 1'b0;
   endtask

   task automatic wait_sel(input int which, input int target, input int limit);
      int n = 0;
      while (((which == 0) ? int'(if0.sel) : int'(if1.sel)) != target && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (n >= limit) begin
         checks++; failures++;
         $display("FAIL wait_sel%0d: sel never reached %0d within %0d cycles", which, target, limit);
      end
   endtask

   task automatic wait_done(input int which, input int limit);
      int n = 0;
      while (((which == 0) ? (q0.size() != 0 || if0.busy) : (q1.size() != 0 || if1.busy)) && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (n >= limit) begin
         checks++; failures++;
         $display("FAIL wait_done%0d: scan not completed within %0d cycles", which, limit);
      end
   endtask

   initial begin : watchdog
      #200000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : stim
      int n0;
      logic [W-1:0] d;
      if0.start = 0; if0.cont = 0; if0.abort = 0;
      if1.start = 0; if1.cont = 0; if1.abort = 0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_sel", 32'(if0.sel), 0);
      check("reset_busy", 32'(if0.busy), 0);
      check("reset_data_out", 32'(if0.data_out), 0);
      check("reset_valid", 32'(if0.valid), 0);
      check("reset_busy1", 32'(if1.busy), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Alternating pattern, settle 1: sel stepping and exact latency.
      data0 = 16'b1010101010101010;
      @(negedge clk);
      if0.start = 1'b1;
      n0 = cyc + 1;
      q0.push_back('{word: data0, t: n0 + LAT0});
      @(negedge clk);
      if0.start = 1'b0;
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         check($sformatf("sel_step_%0d", i), 32'(if0.sel), i);
         @(negedge clk);
      end
      check("busy_in_done", 32'(if0.busy), 1);
      @(negedge clk);
      check("busy_after_done", 32'(if0.busy), 0);
      check("hold_cycle", cyc, n0 + LAT0);
      last0 = 16'hAAAA;

      // Settle 0: bit ordering at both ends.
      data1 = 16'h8001;
      pulse_start(1, 1);
      wait_done(1, 60);
      check("settle0_data_out", 32'(if1.data_out), 32'h8001);

      // Continuous mode with data changed between scans; start pulses ignored.
      data0 = 16'h00FF;
      if0.cont = 1'b1;
      pulse_start(0, 1);
      n0 = q0[0].t;
      while (cyc < n0) @(negedge clk);
      data0 = 16'hFF00;
      q0.push_back('{word: 16'hFF00, t: n0 + LAT0});
      q0.push_back('{word: 16'hFF00, t: n0 + 2 * LAT0});
      repeat (5) @(negedge clk);
      if0.start = 1'b1;
      @(negedge clk);
      if0.start = 1'b0;
      while (cyc < n0 + LAT0 + 10) @(negedge clk);
      if0.cont = 1'b0;
      wait_done(0, 120);
      check("cont_stopped_busy", 32'(if0.busy), 0);
      last0 = 16'hFF00;

      // Abort at sel 7: no valid, output word kept.
      data0 = W'($urandom);
      pulse_start(0, 0);
      wait_sel(0, 7, 40);
      if0.abort = 1'b1;
      @(negedge clk);
      if0.abort = 1'b0;
      check("abort_busy", 32'(if0.busy), 0);
      check("abort_sel", 32'(if0.sel), 0);
      check("abort_data_kept", 32'(if0.data_out), 32'(last0));
      repeat (40) @(negedge clk);
      check("abort_stays_idle", 32'(if0.busy), 0);

      // Abort together with start in IDLE: abort wins.
      if0.abort = 1'b1;
      if0.start = 1'b1;
      @(negedge clk);
      if0.abort = 1'b0;
      if0.start = 1'b0;
      check("abort_start_busy", 32'(if0.busy), 0);
      repeat (5) @(negedge clk);
      check("abort_start_idle", 32'(if0.busy), 0);

      data0 = W'($urandom);
      pulse_start(0, 1);
      wait_done(0, 60);

      // Asynchronous reset mid-scan at sel 9.
      data0 = W'($urandom);
      pulse_start(0, 0);
      wait_sel(0, 9, 40);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_sel", 32'(if0.sel), 0);
      check("async_rst_busy", 32'(if0.busy), 0);
      check("async_rst_data", 32'(if0.data_out), 0);
      check("async_rst_valid", 32'(if0.valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("post_rst_busy", 32'(if0.busy), 0);
      check("post_rst_sel", 32'(if0.sel), 0);

      // Randomised words on both sequencers, including the all-ones/all-zeros corners.
      for (int k = 0; k < 8; k++) begin
         d = (k == 0) ? '1 : (k == 1) ? '0 : W'($urandom);
         if (k % 2 == 0) begin
            data0 = d;
            pulse_start(0, 1);
            wait_done(0, 60);
         end else begin
            data1 = d;
            pulse_start(1, 1);
            wait_done(1, 40);
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      if (q0.size() != 0 || q1.size() != 0) begin
         checks++; failures++;
         $display("FAIL pending_words: got %0d/%0d outstanding, required 0", q0.size(), q1.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
